// File: rtl/modbus_reg_bank.sv
// Modbus RTU register bank: N_HOLD holding registers (03/06) and N_INPUT input registers (04).
// Validates each request against the register map, streams read words into the TX buffer and reports completion.
module modbus_reg_bank #(
  parameter int unsigned N_HOLD     = 8,
  parameter int unsigned N_INPUT    = 8,
  parameter logic [15:0] HOLD_BASE  = 16'h0000,
  parameter logic [15:0] INPUT_BASE = 16'h0000,
  parameter int unsigned MAX_QTY    = 8,
  parameter logic [15:0] HOLD_RST   = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_vld,
  input  logic [7:0]             req_func,
  input  logic [15:0]            req_addr,
  input  logic [15:0]            req_data,
  input  logic [N_INPUT*16-1:0]  input_regs,
  output logic                   req_busy,
  output logic                   req_drop,
  output logic                   buf_wen,
  output logic [7:0]             buf_addr,
  output logic [15:0]            buf_wdata,
  output logic                   rsp_done,
  output logic [7:0]             rsp_exception,
  output logic [7:0]             rsp_qty,
  output logic [N_HOLD*16-1:0]   hold_regs_o,
  output logic [N_HOLD-1:0]      hold_update
);

  typedef enum logic [2:0] {IDLE, CHECK, READ, WRITE, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  func_q;
  logic [15:0] addr_q, data_q;
  logic [6:0]  off_q, idx_q;
  logic [15:0] hold_q [N_HOLD];
  logic [15:0] snap   [N_INPUT];

  logic        is_read;
  logic [15:0] base_c;
  logic [16:0] n_c, start17, end17, lim17;
  logic [6:0]  off_c, rd_ix;
  logic [7:0]  exc_c;
  logic [15:0] rd_word;

  logic                busy_nx, drop_nx, wen_nx, done_nx;
  logic [7:0]          addr_nx, exc_nx, qty_nx;
  logic [15:0]         wdata_nx;
  logic [N_HOLD-1:0]   upd_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Request validation; 17-bit bounds so start+qty cannot wrap past 0xFFFF.
  always_comb begin
    is_read = (func_q == 8'h03) || (func_q == 8'h04);
    base_c  = (func_q == 8'h04) ? INPUT_BASE : HOLD_BASE;
    n_c     = (func_q == 8'h04) ? 17'(N_INPUT) : 17'(N_HOLD);
    start17 = {1'b0, addr_q};
    end17   = start17 + {1'b0, data_q};
    lim17   = {1'b0, base_c} + n_c;
    off_c   = addr_q[6:0] - base_c[6:0];
    exc_c   = '0;
    if (!(is_read || func_q == 8'h06))
      exc_c = 8'h01;
    else if (is_read && (data_q == '0 || data_q > 16'(MAX_QTY)))
      exc_c = 8'h03;
    else if (addr_q < base_c || (is_read ? (end17 > lim17) : (start17 >= lim17)))
      exc_c = 8'h02;
  end

  // Word for the next buffer slot; the first word comes straight from input_regs
  // because the snapshot is being loaded on the same edge.
  always_comb begin
    rd_ix   = (state == CHECK) ? off_c : off_q + idx_q + 7'd1;
    rd_word = '0;
    if (func_q == 8'h03) begin
      for (int unsigned k = 0; k < N_HOLD; k++)
        if (rd_ix == k[6:0]) rd_word = hold_q[k];
    end else begin
      for (int unsigned k = 0; k < N_INPUT; k++)
        if (rd_ix == k[6:0]) rd_word = (state == CHECK) ? input_regs[16*k +: 16] : snap[k];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (req_vld) state_nx = CHECK;
      CHECK: begin
        if (exc_c != '0)  state_nx = DONE;
        else if (is_read) state_nx = READ;
        else              state_nx = WRITE;
      end
      READ:  if (({1'b0, idx_q} + 8'd1) >= data_q[7:0]) state_nx = DONE;
      WRITE: state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_nx  = (state_nx != IDLE);
    drop_nx  = req_vld && (state != IDLE);
    wen_nx   = (state_nx == READ);
    done_nx  = (state_nx == DONE);
    addr_nx  = buf_addr;
    wdata_nx = buf_wdata;
    exc_nx   = rsp_exception;
    qty_nx   = rsp_qty;
    if (wen_nx) begin
      addr_nx  = (state == CHECK) ? '0 : {1'b0, idx_q + 7'd1};
      wdata_nx = rd_word;
    end
    if (done_nx) begin
      exc_nx = (state == CHECK) ? exc_c : '0;
      qty_nx = (state == READ) ? data_q[7:0] : '0;
    end
    for (int unsigned k = 0; k < N_HOLD; k++)
      upd_nx[k] = (state == WRITE) && (off_q == k[6:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_busy      <= 1'b0;
      req_drop      <= 1'b0;
      buf_wen       <= 1'b0;
      buf_addr      <= '0;
      buf_wdata     <= '0;
      rsp_done      <= 1'b0;
      rsp_exception <= '0;
      rsp_qty       <= '0;
      hold_update   <= '0;
    end else begin
      req_busy      <= busy_nx;
      req_drop      <= drop_nx;
      buf_wen       <= wen_nx;
      buf_addr      <= addr_nx;
      buf_wdata     <= wdata_nx;
      rsp_done      <= done_nx;
      rsp_exception <= exc_nx;
      rsp_qty       <= qty_nx;
      hold_update   <= upd_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      off_q  <= '0;
      idx_q  <= '0;
      for (int unsigned k = 0; k < N_HOLD; k++)  hold_q[k] <= HOLD_RST;
      for (int unsigned k = 0; k < N_INPUT; k++) snap[k]   <= '0;
    end else begin
      if (state == IDLE && req_vld) begin
        func_q <= req_func;
        addr_q <= req_addr;
        data_q <= req_data;
      end
      if (state == CHECK) begin
        off_q <= off_c;
        idx_q <= '0;
        for (int unsigned k = 0; k < N_INPUT; k++) snap[k] <= input_regs[16*k +: 16];
      end
      if (state == READ) idx_q <= idx_q + 7'd1;
      if (state == WRITE)
        for (int unsigned k = 0; k < N_HOLD; k++)
          if (off_q == k[6:0]) hold_q[k] <= data_q;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < N_HOLD; k++) hold_regs_o[16*k +: 16] = hold_q[k];
  end

endmodule

// File: tb/tb_modbus_reg_bank.sv
// Directed bench for modbus_reg_bank with HOLD_BASE = 0x0010, other parameters at defaults.
module tb_modbus_reg_bank;

  localparam int NH = 8;
  localparam int NI = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_vld = 1'b0;
  logic [7:0]        req_func = '0;
  logic [15:0]       req_addr = '0;
  logic [15:0]       req_data = '0;
  logic [NI*16-1:0]  input_regs = '0;
  logic              req_busy, req_drop, buf_wen, rsp_done;
  logic [7:0]        buf_addr, rsp_exception, rsp_qty;
  logic [15:0]       buf_wdata;
  logic [NH*16-1:0]  hold_regs_o;
  logic [NH-1:0]     hold_update;

  modbus_reg_bank #(.HOLD_BASE(16'h0010)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_func(req_func),
    .req_addr(req_addr), .req_data(req_data), .input_regs(input_regs),
    .req_busy(req_busy), .req_drop(req_drop), .buf_wen(buf_wen),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .rsp_done(rsp_done),
    .rsp_exception(rsp_exception), .rsp_qty(rsp_qty),
    .hold_regs_o(hold_regs_o), .hold_update(hold_update)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          n_wr, done_cyc, done_cnt, drop_cnt;
  int          wr_cyc [64];
  logic [7:0]  wr_addr [64];
  logic [15:0] wr_data [64];
  logic [7:0]  done_exc, done_qty;
  logic [NH-1:0] done_upd;
  logic        busy1;
  logic [15:0] exp_hold [NH];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [NH*16-1:0] packed_hold();
    logic [NH*16-1:0] v;
    for (int k = 0; k < NH; k++) v[16*k +: 16] = exp_hold[k];
    return v;
  endfunction

  task automatic set_inputs();
    for (int k = 0; k < NI; k++) input_regs[16*k +: 16] = 16'h1000 + 16'(k);
  endtask

  // Strobe one request in cycle 0 and record 40 cycles of DUT activity.
  task automatic run(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                     input bit mutate, input int drop_at, input int rst_at);
    n_wr = 0; done_cyc = -1; done_cnt = 0; drop_cnt = 0;
    done_exc = '0; done_qty = '0; done_upd = '0; busy1 = 1'b0;
    @(posedge clk); #1;
    req_func = f; req_addr = a; req_data = d; req_vld = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      req_vld = (c == drop_at);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", req_busy, 1'b0);
        check("rst_wen", buf_wen, 1'b0);
        check("rst_addr", buf_addr, 8'h00);
        check("rst_wdata", buf_wdata, 16'h0000);
        check("rst_hold", hold_regs_o, 128'h0);
      end
      if (c == rst_at + 2) rst_n = 1'b1;
      if (c == 1) busy1 = req_busy;
      if (buf_wen && n_wr < 64) begin
        wr_cyc[n_wr] = c; wr_addr[n_wr] = buf_addr; wr_data[n_wr] = buf_wdata;
        n_wr++;
      end
      if (req_drop) drop_cnt++;
      if (rsp_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c; done_exc = rsp_exception; done_qty = rsp_qty; done_upd = hold_update;
        end
      end
      if (mutate && c >= 2) input_regs = {NI{16'hDEAD}};
    end
  endtask

  task automatic expect_exc(input string tag, input logic [7:0] f, input logic [15:0] a,
                            input logic [15:0] d, input logic [7:0] code);
    run(f, a, d, 1'b0, 0, 0);
    check({tag, "_exc"}, done_exc, code);
    check({tag, "_cyc"}, done_cyc, 2);
    check({tag, "_nwr"}, n_wr, 0);
    check({tag, "_qty"}, done_qty, 8'h00);
  endtask

  initial begin
    for (int k = 0; k < NH; k++) exp_hold[k] = 16'h0000;
    set_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", req_busy, 1'b0);
    check("reset_wen", buf_wen, 1'b0);
    check("reset_done", rsp_done, 1'b0);
    check("reset_exc", rsp_exception, 8'h00);
    check("reset_hold", hold_regs_o, packed_hold());
    rst_n = 1'b1;

    // Write 0xBEEF to holding register 2, then read it back.
    run(8'h06, 16'h0012, 16'hBEEF, 1'b0, 0, 0);
    exp_hold[2] = 16'hBEEF;
    check("wr_busy1", busy1, 1'b1);
    check("wr_cyc", done_cyc, 3);
    check("wr_exc", done_exc, 8'h00);
    check("wr_qty", done_qty, 8'h00);
    check("wr_upd", done_upd, 8'b0000_0100);
    check("wr_hold", hold_regs_o, packed_hold());
    run(8'h03, 16'h0012, 16'd1, 1'b0, 0, 0);
    check("rd1_nwr", n_wr, 1);
    check("rd1_addr", wr_addr[0], 8'h00);
    check("rd1_data", wr_data[0], 16'hBEEF);
    check("rd1_wcyc", wr_cyc[0], 2);
    check("rd1_cyc", done_cyc, 3);
    check("rd1_qty", done_qty, 8'd1);

    // Input burst with input_regs disturbed during the burst.
    set_inputs();
    run(8'h04, 16'h0000, 16'd8, 1'b1, 0, 0);
    check("burst_nwr", n_wr, 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("burst_addr%0d", k), wr_addr[k], 8'(k));
      check($sformatf("burst_data%0d", k), wr_data[k], 16'h1000 + 16'(k));
      check($sformatf("burst_wcyc%0d", k), wr_cyc[k], k + 2);
    end
    check("burst_cyc", done_cyc, 10);
    check("burst_qty", done_qty, 8'd8);
    check("burst_exc", done_exc, 8'h00);
    set_inputs();

    expect_exc("func05", 8'h05, 16'h0010, 16'd1, 8'h01);
    expect_exc("qty0", 8'h03, 16'h0010, 16'd0, 8'h03);
    expect_exc("qty9", 8'h03, 16'h0010, 16'd9, 8'h03);
    expect_exc("range17", 8'h03, 16'h0017, 16'd2, 8'h02);
    expect_exc("wrapffff", 8'h04, 16'hFFFF, 16'd2, 8'h02);
    expect_exc("below", 8'h03, 16'h000F, 16'd1, 8'h02);

    // Range edges.
    run(8'h06, 16'h0017, 16'h1234, 1'b0, 0, 0);
    exp_hold[7] = 16'h1234;
    check("edge_wr_upd", done_upd, 8'b1000_0000);
    run(8'h03, 16'h0017, 16'd1, 1'b0, 0, 0);
    check("edge_rd_exc", done_exc, 8'h00);
    check("edge_rd_data", wr_data[0], 16'h1234);
    check("edge_rd_nwr", n_wr, 1);
    run(8'h06, 16'h0018, 16'h5555, 1'b0, 0, 0);
    check("edge_wr8_exc", done_exc, 8'h02);
    check("edge_wr8_upd", done_upd, 8'h00);
    check("edge_wr8_hold", hold_regs_o, packed_hold());

    // Request strobed while busy is dropped.
    run(8'h04, 16'h0000, 16'd8, 1'b0, 3, 0);
    check("drop_cnt", drop_cnt, 1);
    check("drop_done_cnt", done_cnt, 1);
    check("drop_cyc", done_cyc, 10);
    check("drop_nwr", n_wr, 8);
    check("drop_data7", wr_data[7], 16'h1007);

    // Reset in cycle 4 of a burst aborts it.
    run(8'h04, 16'h0000, 16'd8, 1'b0, 0, 4);
    for (int k = 0; k < NH; k++) exp_hold[k] = 16'h0000;
    check("rstmid_nwr", n_wr, 2);
    check("rstmid_done", done_cnt, 0);
    check("rstmid_hold", hold_regs_o, packed_hold());
    run(8'h03, 16'h0012, 16'd1, 1'b0, 0, 0);
    check("post_rst_cyc", done_cyc, 3);
    check("post_rst_exc", done_exc, 8'h00);
    check("post_rst_data", wr_data[0], 16'h0000);
    check("post_rst_nwr", n_wr, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modbus_reg_bank.md
# modbus_reg_bank

Parametrised Modbus register bank for the RTU slave. It takes over from the single fixed holding register and four fixed input registers, providing N_HOLD holding registers (codes 03/06) and N_INPUT input registers (code 04) at configurable base addresses. Requests arrive from the frame receiver after CRC and exception pre-checks. The block validates each request against its own register map and streams read data word-by-word into the TX DPRAM. It then signals completion, with an exception code where one applies, to the CRC/response builder.

## Interface
- N_HOLD, 8: number of holding registers, 1..64
- N_INPUT, 8: number of input registers, 1..64
- HOLD_BASE, 16'h0000: Modbus address of holding register 0
- INPUT_BASE, 16'h0000: Modbus address of input register 0
- MAX_QTY, 8: largest read quantity accepted, 1..125
- HOLD_RST, 16'h0000: reset value of every holding register

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  1  one-cycle request strobe
- req_func  in  8  function code
- req_addr  in  16  start register address
- req_data  in  16  quantity for 03/04; write value for 06
- input_regs  in  N_INPUT*16  live input-register values; register k occupies bits [16k+15:16k]
- req_busy  out  1  high from acceptance until rsp_done
- req_drop  out  1  one-cycle pulse when req_vld arrives while busy
- buf_wen  out  1  DPRAM write enable
- buf_addr  out  8  DPRAM word address
- buf_wdata  out  16  DPRAM write data
- rsp_done  out  1  one-cycle completion pulse
- rsp_exception  out  8  0 = normal; otherwise Modbus exception code; valid while rsp_done is high
- rsp_qty  out  8  registers written to the buffer; valid while rsp_done is high
- hold_regs_o  out  N_HOLD*16  current holding-register contents
- hold_update  out  N_HOLD  one-hot one-cycle pulse on the register that was written

## Operation
- FSM states: IDLE, CHECK, READ, WRITE, DONE.
- IDLE:
  - A req_vld strobe latches func, addr and data, raises req_busy and moves to CHECK.
  - A req_vld strobe in any other state is ignored and pulses req_drop.
- CHECK (one cycle): captures a snapshot of input_regs so a multi-register read is coherent, then evaluates the request in this priority order:
  - Function not 03, 04 or 06: exception 01.
  - 03 or 04 with quantity 0 or quantity > MAX_QTY: exception 03.
  - 03 or 04 where start < base, or start + qty > base + N: exception 02. The comparison uses 17-bit arithmetic, so there is no 16-bit wrap-around (0xFFFF + 2 is out of range).
  - 06 with the address outside [HOLD_BASE, HOLD_BASE + N_HOLD): exception 02.
  - Any exception goes to DONE with rsp_qty = 0.
  - A valid 03/04 goes to READ; a valid 06 goes to WRITE.
- READ:
  - Issues one buf_wen per cycle, with buf_addr running 0..qty-1.
  - buf_wdata is register (start - base + i). Holding registers are read live; input registers come from the snapshot.
  - After the last word, goes to DONE with rsp_qty = qty.
- WRITE (one cycle):
  - Loads req_data into the addressed holding register and arms hold_update.
  - Goes to DONE with rsp_qty = 0.
- DONE (one cycle):
  - rsp_done = 1, rsp_exception and rsp_qty are valid, and any armed hold_update bit is high.
  - Returns to IDLE with req_busy = 0.
- The write value is unrestricted: any 16-bit value is accepted.

## Timing
- Reset values:
  - FSM returns to IDLE.
  - req_busy, req_drop, buf_wen, rsp_done and hold_update are all 0.
  - buf_addr, buf_wdata, rsp_exception and rsp_qty are 0.
  - Every holding register is HOLD_RST.
- Reset asserted mid-operation aborts immediately. No rsp_done is produced, and a partial buffer fill is abandoned.
- All outputs are registered.
- Cycle numbering, with the req_vld strobe in cycle 0:
  - CHECK is cycle 1 and req_busy is high from cycle 1.
  - For reads, buf_wen is high in cycles 2..qty+1 and rsp_done is in cycle qty+2.
  - For 06, the hold register changes at the end of cycle 2; hold_regs_o shows the new value and hold_update pulses in cycle 3, in the same cycle as rsp_done.
  - For exceptions, rsp_done is in cycle 2.
- A new request is accepted in the first cycle after rsp_done; back-to-back requests give one IDLE cycle between transactions.
- A write is reflected by a read that starts in any later transaction.

## Test plan
- Write then read holding registers: defaults, HOLD_BASE=0x0010. Send 06 addr 0x0012 data 0xBEEF. Required: hold_update = 8'b0000_0100 in cycle 3 together with rsp_done and exception 0. A following 03 addr 0x0012 qty 1 writes 0xBEEF to buf_addr 0.
- Input register burst: input_regs word k = 0x1000+k. Send 04 addr 0 qty 8. Required: buf_wdata 0x1000..0x1007 on buf_addr 0..7 in cycles 2..9, rsp_done in cycle 10, rsp_qty 8. Changing input_regs during cycles 2..9 must not alter the data written.
- Exceptions:
  - func 0x05: exception 01 with rsp_done in cycle 2.
  - 03 qty 0: exception 03.
  - 03 qty 9: exception 03.
  - 03 addr 0x0017 qty 2 with HOLD_BASE=0x10: exception 02.
  - 04 addr 0xFFFF qty 2: exception 02, with no buf_wen in any case.
- Range edge: 03 addr HOLD_BASE+7 qty 1 succeeds. 06 addr HOLD_BASE+8 returns exception 02 and no holding register changes.
- Busy drop: a second req_vld in cycle 3 of an 8-register read gives a req_drop pulse, the first response completes unchanged, and exactly one rsp_done occurs.
- Reset mid-read: rst_n low in cycle 4 of a qty-8 read clears every output and register. The next request after reset completes normally.
